pipe_ctrl_seq: RTL and testbench

- Sequential pipeline stall/flush controller; replaces the purely combinational stall/flush fan-out.
- Sits beside the pipeline and collects stall/flush requests from decode, issue, execute and memory.
- Drives per-stage stall and flush controls.
- Adds three things: a memory-miss wait state, a flush deferred while a miss is outstanding, and a multi-cycle flush window, plus a stall-cycle counter and a miss-timeout flag.

---
 rtl/pipe_ctrl_seq.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_seq.sv
// Sequential stall/flush controller: drives per-stage stall and flush controls from
// decode/issue/execute/memory requests, with a miss wait state and a multi-cycle flush window.
module pipe_ctrl_seq #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_from_decode,
    input  logic             stall_from_issue,
    input  logic             stall_from_execute,
    input  logic             flash_from_execute,
    input  logic             stall_from_memory,
    input  logic             mem_resp_valid,
    output logic             stall_to_pc,
    output logic             stall_to_if_id,
    output logic             stall_to_id_is,
    output logic             stall_to_is,
    output logic             stall_to_is_ex,
    output logic             stall_to_ex_mem,
    output logic             stall_to_mem_cmt,
    output logic             flash_to_if_id,
    output logic             flash_to_id_is,
    output logic             flash_to_iq,
    output logic             flash_to_is_ex,
    output logic             flash_to_ex_mem,
    output logic             flash_to_mem_cmt,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0]  FC    = 4'(FLUSH_CYCLES);
    localparam logic [3:0]  FC_M1 = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] MT    = 16'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic             flush_pending_q, flush_pending_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [15:0]      res_cnt_q, res_cnt_d;
    logic [15:0]      res_inc;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic front_stall;
    logic pc_stall, fe_stall, be_stall, fe_flash, cmt_flash, pend_any;

    assign front_stall = stall_from_decode | stall_from_issue | stall_from_execute;

    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        flush_cnt_d     = flush_cnt_q;
        res_cnt_d       = res_cnt_q;
        stall_cycles_d  = stall_cycles_q;
        mem_timeout_d   = mem_timeout_q;
        pc_stall        = 1'b0;
        fe_stall        = 1'b0;
        be_stall        = 1'b0;
        fe_flash        = 1'b0;
        cmt_flash       = 1'b0;
        res_inc         = (res_cnt_q == MT) ? res_cnt_q : res_cnt_q + 16'd1;
        pend_any        = flush_pending_q | flash_from_execute;

        unique case (state_q)
            RUN: begin
                pc_stall = front_stall;
                fe_stall = front_stall;
                // A miss outranks a redirect; the redirect is remembered and replayed later.
                if (stall_from_memory) begin
                    state_d         = MEM_WAIT;
                    flush_pending_d = flash_from_execute;
                end else if (flash_from_execute) begin
                    fe_flash = 1'b1;
                    pc_stall = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC_M1;
                    end
                end
            end
            MEM_WAIT: begin
                pc_stall  = 1'b1;
                fe_stall  = 1'b1;
                be_stall  = 1'b1;
                cmt_flash = 1'b1;
                if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
                if (res_inc == MT) mem_timeout_d = 1'b1;
                res_cnt_d       = res_inc;
                flush_pending_d = pend_any;
                if (mem_resp_valid) begin
                    res_cnt_d       = '0;
                    flush_pending_d = 1'b0;
                    if (pend_any) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                fe_flash = 1'b1;
                if (stall_from_memory) begin
                    state_d         = MEM_WAIT;
                    flush_pending_d = 1'b1;
                end else if (flash_from_execute) begin
                    flush_cnt_d = FC;
                end else if (flush_cnt_q == 4'd1) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            flush_pending_q <= 1'b0;
            flush_cnt_q     <= '0;
            res_cnt_q       <= '0;
            stall_cycles_q  <= '0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            flush_cnt_q     <= flush_cnt_d;
            res_cnt_q       <= res_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    // Controls are combinational, so they are gated directly by reset.
    assign stall_to_pc      = rst_n & pc_stall;
    assign stall_to_if_id   = rst_n & fe_stall;
    assign stall_to_id_is   = rst_n & fe_stall;
    assign stall_to_is      = rst_n & be_stall;
    assign stall_to_is_ex   = rst_n & be_stall;
    assign stall_to_ex_mem  = rst_n & be_stall;
    assign stall_to_mem_cmt = 1'b0;
    assign flash_to_if_id   = rst_n & fe_flash;
    assign flash_to_id_is   = rst_n & fe_flash;
    assign flash_to_iq      = rst_n & fe_flash;
    assign flash_to_is_ex   = rst_n & fe_flash;
    assign flash_to_ex_mem  = 1'b0;
    assign flash_to_mem_cmt = rst_n & cmt_flash;
    assign state_o          = state_q;
    assign stall_cycles     = stall_cycles_q;
    assign mem_timeout      = mem_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Bench for pipe_ctrl_seq: three parameterisations driven in lockstep, each checked
// every cycle against a behavioural model of the controller rules.
module tb_pipe_ctrl_seq;

    logic clk, rst_n;
    logic dec, iss, exe, flash, mem, resp;

    logic [2:0][12:0] ob;
    logic [2:0][1:0]  st;
    logic [2:0]       to;
    logic [2:0][31:0] sc;
    logic [47:0]      obs [3];
    logic [47:0]      exp_v [3];

    int n_vec = 0;
    int n_err = 0;

    // model configuration, one entry per instance
    int     fc_m [3] = '{2, 4, 1};
    int     mt_m [3] = '{8, 3, 1024};
    longint cmax [3] = '{255, 64'hFFFF_FFFF, 64'hFFFF_FFFF};

    // model state: mode 0 run, 1 waiting on miss, 2 flushing
    int     mode [3];
    int     left [3];
    int     wlen [3];
    bit     pend [3];
    bit     tmo  [3];
    longint scnt [3];

    localparam logic [6:0] IDL = 7'h40, MEM = 7'h42, FL = 7'h44, RSP = 7'h41;
    localparam logic [6:0] MF = 7'h46, RST1 = 7'h3F, RST0 = 7'h00, STF = 7'h7C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int FCP = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        localparam int MTP = (g == 0) ? 8 : (g == 1) ? 3 : 1024;
        localparam int CWP = (g == 0) ? 8 : 32;
        logic [CWP-1:0] scw;
        pipe_ctrl_seq #(.FLUSH_CYCLES(FCP), .MEM_TIMEOUT(MTP), .CNT_W(CWP)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .stall_from_decode(dec), .stall_from_issue(iss), .stall_from_execute(exe),
            .flash_from_execute(flash), .stall_from_memory(mem), .mem_resp_valid(resp),
            .stall_to_pc(ob[g][12]), .stall_to_if_id(ob[g][11]), .stall_to_id_is(ob[g][10]),
            .stall_to_is(ob[g][9]), .stall_to_is_ex(ob[g][8]), .stall_to_ex_mem(ob[g][7]),
            .stall_to_mem_cmt(ob[g][6]), .flash_to_if_id(ob[g][5]), .flash_to_id_is(ob[g][4]),
            .flash_to_iq(ob[g][3]), .flash_to_is_ex(ob[g][2]), .flash_to_ex_mem(ob[g][1]),
            .flash_to_mem_cmt(ob[g][0]), .state_o(st[g]), .stall_cycles(scw),
            .mem_timeout(to[g])
        );
        assign sc[g]  = 32'(scw);
        assign obs[g] = {st[g], to[g], sc[g], ob[g]};
    end

    task automatic model_reset(input int d);
        mode[d] = 0; left[d] = 0; wlen[d] = 0; pend[d] = 0; tmo[d] = 0; scnt[d] = 0;
    endtask

    task automatic model_next(input int d);
        if (!rst_n) begin
            model_reset(d);
        end else if (mode[d] == 0) begin
            if (mem) begin
                mode[d] = 1; pend[d] = flash; wlen[d] = 0;
            end else if (flash && fc_m[d] > 1) begin
                mode[d] = 2; left[d] = fc_m[d] - 1;
            end
        end else if (mode[d] == 1) begin
            if (scnt[d] < cmax[d]) scnt[d] = scnt[d] + 1;
            wlen[d] = wlen[d] + 1;
            if (wlen[d] >= mt_m[d]) tmo[d] = 1;
            if (flash) pend[d] = 1;
            if (resp) begin
                wlen[d] = 0;
                if (pend[d]) begin mode[d] = 2; left[d] = fc_m[d]; pend[d] = 0; end
                else mode[d] = 0;
            end
        end else begin
            if (mem) begin mode[d] = 1; pend[d] = 1; end
            else if (flash) left[d] = fc_m[d];
            else if (left[d] == 1) mode[d] = 0;
            else left[d] = left[d] - 1;
        end
    endtask

    function automatic logic [47:0] model_out(input int d);
        logic [12:0] b;
        logic fr, fl;
        b  = '0;
        fr = dec | iss | exe;
        fl = flash & ~mem;
        if (rst_n) begin
            if (mode[d] == 0) begin
                b[12] = fr & ~fl; b[11] = fr; b[10] = fr; b[5:2] = {4{fl}};
            end else if (mode[d] == 1) begin
                b[12:7] = '1; b[0] = 1'b1;
            end else begin
                b[5:2] = '1;
            end
        end
        return {2'(mode[d]), tmo[d], 32'(scnt[d]), b};
    endfunction

    // advance one clock (model follows the held inputs), then apply v mid-cycle
    task automatic drive(input logic [6:0] v);
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_next(d);
        @(negedge clk);
        {rst_n, dec, iss, exe, flash, mem, resp} = v;
        if (!rst_n) for (int d = 0; d < 3; d++) model_reset(d);
        #1;
        for (int d = 0; d < 3; d++) exp_v[d] = model_out(d);
    endtask

    task automatic test_reset();
        logic [6:0] seq [5] = '{RST1, RST1, RST1, IDL, IDL};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL reset dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_miss();
        logic [6:0] seq [9] = '{MEM, IDL, IDL, IDL, IDL, IDL, RSP, IDL, IDL};
        for (int i = 0; i < 9; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL miss dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
        n_vec++;
        if (sc[2] !== 32'd6) begin
            n_err++;
            $display("FAIL miss_count got %0d want 6", sc[2]);
        end
    endtask

    task automatic test_deferred();
        logic [6:0] seq [11] = '{MEM, IDL, IDL, FL, IDL, RSP, IDL, IDL, IDL, IDL, IDL};
        for (int i = 0; i < 11; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL deferred dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [6:0] seq [10] = '{MF, IDL, IDL, 7'h43, RSP, IDL, IDL, IDL, IDL, IDL};
        for (int i = 0; i < 10; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL conflict dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_run_flush();
        logic [6:0] seq [16] = '{STF, IDL, IDL, FL, IDL, FL, IDL, FL, MEM, IDL, FL,
                                 RSP, IDL, STF, IDL, IDL};
        for (int i = 0; i < 16; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL run_flush dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] seq [17] = '{RST0, IDL, MEM, IDL, IDL, IDL, IDL, IDL, IDL, IDL, IDL,
                                 IDL, IDL, RSP, IDL, IDL, IDL};
        for (int i = 0; i < 17; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL timeout dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
        n_vec++;
        if (to[0] !== 1'b1 || to[2] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky got %b%b want 10", to[0], to[2]);
        end
        drive(RST0);
        n_vec++;
        if (to[0] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear got %b want 0", to[0]);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [6:0] seq [9] = '{IDL, MF, RSP, IDL, RST0, RST0, IDL, IDL, IDL};
        for (int i = 0; i < 9; i++) begin
            drive(seq[i]);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL mid_flush dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        drive(RST0);
        drive(IDL);
        drive(MEM);
        for (int i = 0; i < 301; i++) begin
            drive(i == 300 ? RSP : IDL);
            if (i % 50 == 0 || i == 300) begin
                for (int d = 0; d < 3; d++) begin
                    n_vec++;
                    if (obs[d] !== exp_v[d]) begin
                        n_err++;
                        $display("FAIL saturate dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                    end
                end
            end
        end
        drive(IDL);
        n_vec++;
        if (sc[0] !== 32'd255 || sc[1] !== 32'd301) begin
            n_err++;
            $display("FAIL saturate_count got %0d/%0d want 255/301", sc[0], sc[1]);
        end
    endtask

    task automatic test_random();
        logic [6:0] v;
        for (int i = 0; i < 600; i++) begin
            v[6] = ($urandom % 150) != 0;
            v[5] = 1'($urandom % 2);
            v[4] = 1'($urandom % 2);
            v[3] = 1'($urandom % 2);
            v[2] = ($urandom % 6) == 0;
            v[1] = ($urandom % 8) == 0;
            v[0] = ($urandom % 4) == 0;
            drive(v);
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL random dut%0d step%0d got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {dec, iss, exe, flash, mem, resp} = '0;
        for (int d = 0; d < 3; d++) model_reset(d);
        test_reset();
        test_miss();
        test_deferred();
        test_conflict();
        test_run_flush();
        test_timeout();
        test_reset_mid_flush();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
